// File: rtl/timer_ctrl.sv
`timescale 1ns/1ps
// Countdown timer controller: three debounced buttons drive an IDLE/RUN/PAUSE/DONE FSM
// that issues one-cycle inc/dec/clr commands to an external BCD datapath.
//
// state | meaning
// IDLE  | count editable: inc/clr commands accepted, start begins countdown if nonzero
// RUN   | prescaler running, dec_pulse once per TICK_DIV cycles
// PAUSE | prescaler frozen at its current value
// DONE  | count reached zero, alarm high, blank blinking
module timer_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TICK_DIV        = 6000000,
    parameter int BLINK_DIV       = 3000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc,
    input  logic       btn_start,
    input  logic       btn_clr,
    input  logic       cnt_zero,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       clr_pulse,
    output logic [1:0] state,
    output logic       alarm,
    output logic       blank
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BL_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [DB_W-1:0]  DB_SAT   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);
    localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    // Button index: 0 = inc, 1 = start, 2 = clr
    logic [2:0]      raw;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      stable;
    logic [2:0]      stable_d;
    logic [2:0]      ev;

    assign raw = {btn_clr, btn_start, btn_inc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
            stable   <= '0;
            stable_d <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!raw[i]) begin
                    db_cnt[i] <= '0;
                    stable[i] <= 1'b0;
                end else begin
                    if (db_cnt[i] != DB_SAT) begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                    stable[i] <= (db_cnt[i] >= DB_LAST);
                end
            end
            stable_d <= stable;
        end
    end

    assign ev = stable & ~stable_d;

    logic ev_clr;
    logic ev_start;
    logic ev_inc;

    assign ev_clr   = ev[2];
    assign ev_start = ev[1] & ~ev[2];
    assign ev_inc   = ev[0] & ~ev[1] & ~ev[2];

    state_t           state_q, state_n;
    logic [PSC_W-1:0] psc_q, psc_n;
    logic [BL_W-1:0]  blink_q, blink_n;
    logic             blank_q, blank_n;
    logic             inc_q, inc_n;
    logic             dec_q, dec_n;
    logic             clr_q, clr_n;
    logic             alarm_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            psc_q   <= '0;
            blink_q <= '0;
            blank_q <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            clr_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_n;
            psc_q   <= psc_n;
            blink_q <= blink_n;
            blank_q <= blank_n;
            inc_q   <= inc_n;
            dec_q   <= dec_n;
            clr_q   <= clr_n;
            alarm_q <= (state_n == S_DONE);
        end
    end

    always_comb begin
        state_n = state_q;
        psc_n   = psc_q;
        blink_n = '0;
        blank_n = 1'b0;
        inc_n   = 1'b0;
        dec_n   = 1'b0;
        clr_n   = 1'b0;

        case (state_q)
            S_IDLE: begin
                psc_n = '0;
                if (ev_clr) begin
                    clr_n = 1'b1;
                end else if (ev_start) begin
                    if (!cnt_zero) begin
                        state_n = S_RUN;
                    end
                end else if (ev_inc) begin
                    inc_n = 1'b1;
                end
            end

            S_RUN: begin
                // While dec_pulse is out the datapath has not yet decremented, so
                // cnt_zero is first meaningful in the cycle after it.
                if (ev_clr) begin
                    clr_n   = 1'b1;
                    psc_n   = '0;
                    state_n = S_IDLE;
                end else if (ev_start) begin
                    state_n = S_PAUSE;
                end else if (cnt_zero && !dec_q) begin
                    psc_n   = '0;
                    state_n = S_DONE;
                end else if (psc_q == PSC_LAST) begin
                    psc_n = '0;
                    dec_n = 1'b1;
                end else begin
                    psc_n = psc_q + PSC_W'(1);
                end
            end

            S_PAUSE: begin
                if (ev_clr) begin
                    clr_n   = 1'b1;
                    psc_n   = '0;
                    state_n = S_IDLE;
                end else if (ev_start) begin
                    state_n = S_RUN;
                end
            end

            S_DONE: begin
                if (ev != 3'b000) begin
                    clr_n   = ev_clr;
                    psc_n   = '0;
                    state_n = S_IDLE;
                end else if (blink_q == BL_LAST) begin
                    blink_n = '0;
                    blank_n = ~blank_q;
                end else begin
                    blink_n = blink_q + BL_W'(1);
                    blank_n = blank_q;
                end
            end

            default: begin
                state_n = S_IDLE;
                psc_n   = '0;
            end
        endcase
    end

    assign state     = state_q;
    assign inc_pulse = inc_q;
    assign dec_pulse = dec_q;
    assign clr_pulse = clr_q;
    assign alarm     = alarm_q;
    assign blank     = blank_q;

endmodule
